apb_regfile_slave: RTL

//  Parametrised APB4 slave: register file with NUM_REGS words, programmable wait states,

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_reg_decode.sv | 46 ++++
 rtl/apb_regfile_slave.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file slave.
//   apb_state_e : two-state transfer FSM (IDLE / ACCESS)
//   WAIT_CNT_W  : width of the wait-state counter (0..15 wait states)
//   bytes_of()  : number of byte lanes in a data word of the given width
package apb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int WAIT_CNT_W = 4;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/apb_reg_decode.sv
// Combinational address decoder for the APB register file.
//   paddr        in   byte address of the current transfer
//   idx          out  word index (paddr with the byte-offset bits dropped)
//   misalign     out  byte-offset bits of paddr are non-zero
//   out_of_range out  idx addresses a word beyond the implemented registers
//   ro_hit       out  idx addresses an implemented read-only register
module apb_reg_decode
    import apb_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    localparam int                 LSB        = $clog2(bytes_of(DATA_WIDTH)),
    localparam int                 IDX_W      = ADDR_WIDTH - LSB
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    output logic [IDX_W-1:0]      idx,
    output logic                  misalign,
    output logic                  out_of_range,
    output logic                  ro_hit
);

    assign idx = paddr[ADDR_WIDTH-1:LSB];

    // An 8-bit data path has no byte-offset bits, so nothing can be misaligned.
    generate
        if (LSB == 0) begin : g_no_offset
            assign misalign = 1'b0;
        end else begin : g_offset
            assign misalign = |paddr[LSB-1:0];
        end
    endgenerate

    // One extra bit lets NUM_REGS == 2**IDX_W compare without overflowing.
    assign out_of_range = ({1'b0, idx} >= (IDX_W + 1)'(NUM_REGS));

    // Read-only lookup: OR of matching mask bits, so out-of-range indices yield 0.
    always_comb begin
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ro_hit = ro_hit | ((idx == IDX_W'(i)) & RO_MASK[i]);
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 slave exposing NUM_REGS word registers with byte strobes, programmable
// wait states, read-only status registers and PSLVERR.
//   PCLK/PRESETn            clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE     APB control
//   PADDR/PWDATA/PSTRB      APB address, write data, byte strobes
//   PRDATA/PREADY/PSLVERR   APB response
//   status_i                hardware values returned for read-only registers
//   regs_o                  flattened register contents, register 0 in the LSBs
//   wr_pulse_o              one-cycle pulse per register after a committed write
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                  ADDR_WIDTH  = 8,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    localparam int                 NBYTES      = bytes_of(DATA_WIDTH),
    localparam int                 LSB         = $clog2(NBYTES),
    localparam int                 IDX_W       = ADDR_WIDTH - LSB
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [NBYTES-1:0]              PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    apb_state_e              state_r;
    apb_state_e              state_nxt_s;
    logic [WAIT_CNT_W-1:0]   cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    write_r;
    logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]     wr_pulse_r;

    logic [IDX_W-1:0]        idx_s;
    logic                    misalign_s;
    logic                    oor_s;
    logic                    ro_hit_s;
    logic                    setup_s;
    logic                    pready_s;
    logic                    err_s;
    logic                    commit_s;
    logic [NUM_REGS-1:0]     commit_vec_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;
    logic [DATA_WIDTH-1:0]   prdata_s;

    // Decode the address captured in the setup phase, not the live bus.
    apb_reg_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_decode (
        .paddr        (addr_r),
        .idx          (idx_s),
        .misalign     (misalign_s),
        .out_of_range (oor_s),
        .ro_hit       (ro_hit_s)
    );

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: a dropped PSEL aborts the access phase.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (setup_s) state_nxt_s = ACCESS;
                else         state_nxt_s = IDLE;
            end
            ACCESS: begin
                if (!PSEL)         state_nxt_s = IDLE;
                else if (pready_s) state_nxt_s = IDLE;
                else               state_nxt_s = ACCESS;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: handshake, error classification, commit strobes and read mux.
    always_comb begin
        setup_s  = (state_r == IDLE) & PSEL & ~PENABLE;
        pready_s = (state_r == ACCESS) & (cnt_r == {WAIT_CNT_W{1'b0}}) & PSEL & PENABLE;
        err_s    = misalign_s | oor_s | (write_r & ro_hit_s);
        commit_s = pready_s & write_r & ~err_s;
        commit_vec_s = {NUM_REGS{1'b0}};
        rd_data_s    = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            commit_vec_s[i] = commit_s & (idx_s == IDX_W'(i));
            rd_data_s = rd_data_s | ({DATA_WIDTH{idx_s == IDX_W'(i)}} &
                        (RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i]));
        end
        if (pready_s && !write_r && !err_s) begin
            prdata_s = rd_data_s;
        end else begin
            prdata_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Setup-phase capture of address/direction and the wait-state countdown.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_r   <= {WAIT_CNT_W{1'b0}};
            addr_r  <= {ADDR_WIDTH{1'b0}};
            write_r <= 1'b0;
        end else if (setup_s) begin
            cnt_r   <= WAIT_CNT_W'(WAIT_STATES);
            addr_r  <= PADDR;
            write_r <= PWRITE;
        end else if ((state_r == ACCESS) && PSEL && (cnt_r != {WAIT_CNT_W{1'b0}})) begin
            cnt_r   <= cnt_r - WAIT_CNT_W'(1);
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    // Register array: byte-strobed merge of write data on a committed write.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (commit_vec_s[i] && PSTRB[k]) begin
                        regs_r[i][k*8 +: 8] <= PWDATA[k*8 +: 8];
                    end
                end
            end
        end
    end

    // Write pulse: fires the cycle after commit, independent of PSTRB.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_pulse_r <= {NUM_REGS{1'b0}};
        end else begin
            wr_pulse_r <= commit_vec_s;
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
            assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
        end
    endgenerate

    assign PREADY     = pready_s;
    assign PSLVERR    = pready_s & err_s;
    assign PRDATA     = prdata_s;
    assign wr_pulse_o = wr_pulse_r;

endmodule
